switch_input_loader: RTL and testbench

//  Board-level front end that turns slide switches plus one push-button into datapath stimulus.
//  A debounced key press either loads a DATA_W-bit operand in SW_W-bit chunks (sel_data=1) or

---
 rtl/switch_input_loader_pkg.sv | 27 ++
 rtl/switch_input_loader_if.sv | 30 +++
 rtl/switch_input_loader_key_debounce.sv | 105 ++++++++++
 rtl/switch_input_loader.sv | 106 ++++++++++
 tb/tb_switch_input_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_input_loader_pkg.sv
// Shared definitions for the switch/push-button loader: debounce states, chunk sizing
// helpers and reset constants.
package swload_pkg;

  typedef enum logic [1:0] {
    REL   = 2'd0,
    PWAIT = 2'd1,
    HELD  = 2'd2,
    RWAIT = 2'd3
  } deb_state_e;

  localparam deb_state_e DEB_RST_STATE = REL;
  // Synchroniser flops reset to the released key level so reset never fakes a press.
  localparam logic KEY_IDLE_LVL = 1'b1;
  localparam logic SEL_RST_LVL  = 1'b0;

  function automatic int nchunk(input int data_w, input int sw_w);
    return (data_w + sw_w - 1) / sw_w;
  endfunction

  function automatic int cidx_w(input int data_w, input int sw_w);
    int n;
    n = nchunk(data_w, sw_w);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_input_loader_if.sv
// Board-side signal bundle of the loader: master = pins/stimulus side, slave = loader.
interface switch_input_loader_if
  import swload_pkg::*;
#(
  parameter int SW_W   = 8,
  parameter int DATA_W = 16,
  parameter int CTRL_W = 9
);
  localparam int CIDX_W = cidx_w(DATA_W, SW_W);

  logic              key_n;
  logic              sel_data;
  logic [SW_W-1:0]   sw_val;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [CTRL_W-1:0] ctrl_out;
  logic              step_en;
  logic [CIDX_W-1:0] chunk_idx;

  modport master (
    output key_n, sel_data, sw_val, ctrl_in,
    input  data_out, data_valid, ctrl_out, step_en, chunk_idx
  );

  modport slave (
    input  key_n, sel_data, sw_val, ctrl_in,
    output data_out, data_valid, ctrl_out, step_en, chunk_idx
  );
endinterface

// File: rtl/switch_input_loader_key_debounce.sv
// Push-button synchroniser + debounce FSM producing a one-cycle press_evt_o.
// Optional auto-repeat while held: define SWLOAD_AUTOREPEAT_EN.
//  state | meaning
//  REL   | key released and stable
//  PWAIT | key seen low, counting stable low cycles
//  HELD  | press accepted, key held
//  RWAIT | key seen high, counting stable high cycles
module key_debounce
  import swload_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int RPT_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_evt_o
);
  localparam int DCNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DEB_MAX  = DCNT_W'(DEB_CYCLES);

  logic [1:0]        key_sync_q;
  logic              key_s;
  deb_state_e        state_q, state_d;
  logic [DCNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic              press_q, press_d;

`ifdef SWLOAD_AUTOREPEAT_EN
  localparam int RCNT_W = $clog2(RPT_CYCLES + 1);
  localparam logic [RCNT_W-1:0] RPT_LAST = RCNT_W'(RPT_CYCLES - 1);
  logic [RCNT_W-1:0] rpt_q, rpt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rpt_q <= '0;
    else        rpt_q <= rpt_d;
  end
`endif

  assign key_s       = key_sync_q[1];
  assign cnt_inc     = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + DCNT_W'(1);
  assign press_evt_o = press_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync_q <= {2{KEY_IDLE_LVL}};
      state_q    <= DEB_RST_STATE;
      cnt_q      <= '0;
      press_q    <= 1'b0;
    end else begin
      key_sync_q <= {key_sync_q[0], key_n_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      press_q    <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    case (state_q)
      REL: begin
        if (!key_s) begin
          state_d = PWAIT;
          cnt_d   = DCNT_W'(1);
        end
      end
      PWAIT: begin
        if (key_s) begin
          state_d = REL;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = RWAIT;
          cnt_d   = DCNT_W'(1);
        end
      end
      RWAIT: begin
        if (!key_s) begin
          state_d = HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d = REL;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = DEB_RST_STATE;
    endcase
`ifdef SWLOAD_AUTOREPEAT_EN
    // Repeat timer runs only while the key stays in HELD; any exit clears it.
    rpt_d = '0;
    if (state_q == HELD && !key_s) begin
      if (rpt_q == RPT_LAST) press_d = 1'b1;
      else                   rpt_d   = rpt_q + RCNT_W'(1);
    end
`endif
  end
endmodule

// File: rtl/switch_input_loader.sv
// Turns debounced key presses into chunked operand loads (sel_data=1) or control-word
// latches with a one-cycle step enable (sel_data=0). Auto-repeat: SWLOAD_AUTOREPEAT_EN.
module switch_input_loader
  import swload_pkg::*;
#(
  parameter int SW_W       = 8,
  parameter int DATA_W     = 16,
  parameter int CTRL_W     = 9,
  parameter int DEB_CYCLES = 50000,
  parameter int RPT_CYCLES = 25000000
) (
  input logic             clk,
  input logic             rst_n,
  switch_input_loader_if.slave bus
);
  localparam int NCHUNK = nchunk(DATA_W, SW_W);
  localparam int CIDX_W = cidx_w(DATA_W, SW_W);
  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NCHUNK - 1);

  logic              press_evt;
  logic [1:0]        sel_sync_q;
  logic              sel_prev_q;
  logic              sel_s, sel_fall;
  logic [DATA_W-1:0] shadow_q, shadow_d, shadow_upd;
  logic [CIDX_W-1:0] chunk_q, chunk_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              step_q, step_d;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .RPT_CYCLES (RPT_CYCLES)
  ) u_deb (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n_i     (bus.key_n),
    .press_evt_o (press_evt)
  );

  assign sel_s    = sel_sync_q[1];
  assign sel_fall = sel_prev_q & ~sel_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sync_q <= {2{SEL_RST_LVL}};
      sel_prev_q <= SEL_RST_LVL;
      shadow_q   <= '0;
      chunk_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      step_q     <= 1'b0;
    end else begin
      sel_sync_q <= {sel_sync_q[0], bus.sel_data};
      sel_prev_q <= sel_s;
      shadow_q   <= shadow_d;
      chunk_q    <= chunk_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      step_q     <= step_d;
    end
  end

  // Bits of a partial last chunk beyond DATA_W simply have no destination.
  always_comb begin
    shadow_upd = shadow_q;
    for (int i = 0; i < DATA_W; i++) begin
      if ((i / SW_W) == int'(chunk_q)) shadow_upd[i] = bus.sw_val[i % SW_W];
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    chunk_d  = chunk_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ctrl_d   = ctrl_q;
    step_d   = 1'b0;
    if (press_evt && sel_s) begin
      shadow_d = shadow_upd;
      if (chunk_q == LAST_IDX) begin
        data_d  = shadow_upd;
        valid_d = 1'b1;
        chunk_d = '0;
      end else begin
        chunk_d = chunk_q + CIDX_W'(1);
      end
    end else if (press_evt) begin
      ctrl_d = bus.ctrl_in;
      step_d = 1'b1;
    end
    // Leaving data mode mid-entry discards the partial operand.
    if (sel_fall && chunk_q != '0) begin
      chunk_d  = '0;
      shadow_d = '0;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.ctrl_out   = ctrl_q;
  assign bus.step_en    = step_q;
  assign bus.chunk_idx  = chunk_q;
endmodule

// File: tb/tb_switch_input_loader.sv
// Directed + randomized bench for switch_input_loader with 16-bit and 12-bit operand instances.
module tb_switch_input_loader;
  localparam int DEB = 4;
  localparam int RPT = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       sel_data = 1'b0;
  logic [7:0] sw_val = '0;
  logic [8:0] ctrl_in = '0;

  int n_checks = 0;
  int n_fail   = 0;

  switch_input_loader_if #(.SW_W(8), .DATA_W(16), .CTRL_W(9)) bus16 ();
  switch_input_loader_if #(.SW_W(8), .DATA_W(12), .CTRL_W(9)) bus12 ();

  assign bus16.key_n = key_n;  assign bus16.sel_data = sel_data;
  assign bus16.sw_val = sw_val; assign bus16.ctrl_in = ctrl_in;
  assign bus12.key_n = key_n;  assign bus12.sel_data = sel_data;
  assign bus12.sw_val = sw_val; assign bus12.ctrl_in = ctrl_in;

  switch_input_loader #(.SW_W(8), .DATA_W(16), .CTRL_W(9), .DEB_CYCLES(DEB), .RPT_CYCLES(RPT))
    dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  switch_input_loader #(.SW_W(8), .DATA_W(12), .CTRL_W(9), .DEB_CYCLES(DEB), .RPT_CYCLES(RPT))
    dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

  always #5 clk = ~clk;

  // pulse counters observed away from the rising edge
  int cyc = 0;
  int v16 = 0, v12 = 0, s16 = 0, s12 = 0;
  int step_times[$];
  always @(negedge clk) begin
    cyc++;
    if (bus16.data_valid) v16++;
    if (bus12.data_valid) v12++;
    if (bus12.step_en) s12++;
    if (bus16.step_en) begin
      s16++;
      step_times.push_back(cyc);
    end
  end

  // reference model: chunks collected per press, operand assembled when complete
  int          q16[$], q12[$];
  logic [31:0] exp_d16 = 0, exp_d12 = 0, exp_ctrl = 0;
  int          exp_v16 = 0, exp_v12 = 0, exp_step = 0;
  logic        cur_sel = 1'b0;
  localparam int NCH16 = (16 + 7) / 8;
  localparam int NCH12 = (12 + 7) / 8;

  function automatic logic [31:0] assemble(input int q[$], input int w);
    logic [31:0] v = 0;
    foreach (q[k]) v = v + (32'(q[k]) << (8 * k));
    return v & ((32'd1 << w) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data16"}, 32'(bus16.data_out), exp_d16);
    chk({tag, ".data12"}, 32'(bus12.data_out), exp_d12);
    chk({tag, ".ctrl16"}, 32'(bus16.ctrl_out), exp_ctrl);
    chk({tag, ".ctrl12"}, 32'(bus12.ctrl_out), exp_ctrl);
    chk({tag, ".cidx16"}, 32'(bus16.chunk_idx), 32'(q16.size()));
    chk({tag, ".cidx12"}, 32'(bus12.chunk_idx), 32'(q12.size()));
    chk({tag, ".valid16"}, 32'(v16), 32'(exp_v16));
    chk({tag, ".valid12"}, 32'(v12), 32'(exp_v12));
    chk({tag, ".step16"}, 32'(s16), 32'(exp_step));
    chk({tag, ".step12"}, 32'(s12), 32'(exp_step));
  endtask

  task automatic model_press();
    if (cur_sel) begin
      q16.push_back(int'(sw_val));
      q12.push_back(int'(sw_val));
      if (q16.size() == NCH16) begin exp_d16 = assemble(q16, 16); q16.delete(); exp_v16++; end
      if (q12.size() == NCH12) begin exp_d12 = assemble(q12, 12); q12.delete(); exp_v12++; end
    end else begin
      exp_ctrl = 32'(ctrl_in);
      exp_step++;
    end
  endtask

  task automatic set_sel(input logic v);
    if (cur_sel && !v) begin q16.delete(); q12.delete(); end
    sel_data = v;
    cur_sel  = v;
    repeat (6) @(negedge clk);
  endtask

  // key held low for 'hold' cycles; accepted only when it covers DEB stable samples
  task automatic press(input int hold);
    @(negedge clk);
    key_n = 1'b0;
    repeat (hold) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    if (hold >= DEB) model_press();
  endtask

  task automatic press_data(input logic [7:0] v, input string tag);
    sw_val = v;
    press(DEB + 2);
    check_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all("reset");

    // 1: two chunks, chunk 0 least significant
    set_sel(1'b1);
    press_data(8'h34, "t1.c0");
    press_data(8'h12, "t1.c1");
    chk("t1.data16_lit", 32'(bus16.data_out), 32'h1234);

    // 2: glitch rejection at the debounce boundary
    set_sel(1'b0);
    ctrl_in = 9'h0F3;
    press(3);
    check_all("t2.glitch3");
    press(DEB - 1 + 2);
    check_all("t2.low5");
    press(DEB);
    check_all("t2.low4_edge");

    // 3: control latch and key-to-output latency
    ctrl_in = 9'h1A5;
    @(negedge clk);
    key_n = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus16.step_en) begin lat = n; break; end
    end
    chk("t3.latency", 32'(lat), 32'(2 + DEB + 1));
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    model_press();
    check_all("t3.ctrl");
    chk("t3.ctrl_lit", 32'(bus16.ctrl_out), 32'h1A5);

    // 4: abort of a partial entry by leaving data mode
    set_sel(1'b1);
    press_data(8'hAA, "t4.partial");
    set_sel(1'b0);
    check_all("t4.abort");
    set_sel(1'b1);
    press_data(8'h01, "t4.c0");
    press_data(8'h02, "t4.c1");
    chk("t4.data16_lit", 32'(bus16.data_out), 32'h0201);

    // 5: partial last chunk drops bits above the operand width
    press_data(8'hCD, "t5.c0");
    press_data(8'hFB, "t5.c1");
    chk("t5.data12_lit", 32'(bus12.data_out), 32'hBCD);

    // 6: reset mid second chunk and mid debounce
    press_data(8'h55, "t6.c0");
    @(negedge clk);
    key_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst.data16", 32'(bus16.data_out), 0);
    chk("t6.rst.data12", 32'(bus12.data_out), 0);
    chk("t6.rst.ctrl", 32'(bus16.ctrl_out), 0);
    chk("t6.rst.cidx", 32'(bus16.chunk_idx), 0);
    chk("t6.rst.valid", 32'({bus16.data_valid, bus16.step_en}), 0);
    key_n = 1'b1;
    q16.delete(); q12.delete();
    exp_d16 = 0; exp_d12 = 0; exp_ctrl = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_all("t6.after_rst");
    press_data(8'h77, "t6.fresh");

    // randomized mix of presses, glitches and mode changes
    for (int it = 0; it < 16; it++) begin
      int r;
      r = $urandom_range(0, 4);
      case (r)
        0, 1: begin
          if (!cur_sel) set_sel(1'b1);
          sw_val = 8'($urandom);
          press($urandom_range(DEB, DEB + 6));
        end
        2: begin
          if (cur_sel) set_sel(1'b0);
          ctrl_in = 9'($urandom);
          press($urandom_range(DEB, DEB + 6));
        end
        3: set_sel(~cur_sel);
        default: press($urandom_range(1, DEB - 1));
      endcase
      check_all($sformatf("rnd%0d", it));
    end

`ifdef SWLOAD_AUTOREPEAT_EN
    set_sel(1'b0);
    ctrl_in = 9'h0C3;
    step_times.delete();
    @(negedge clk);
    key_n = 1'b0;
    repeat (50) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    exp_ctrl = 32'h0C3;
    exp_step += 3;
    check_all("rpt");
    chk("rpt.count", 32'(step_times.size()), 3);
    if (step_times.size() == 3) begin
      chk("rpt.gap1", 32'(step_times[1] - step_times[0]), RPT);
      chk("rpt.gap2", 32'(step_times[2] - step_times[1]), RPT);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
